// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a small valid/ready byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    data_out,
  output logic                          valid,
  input  logic                          ready,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd5;
`endif

  logic          sync1_q, sync2_q, rx_s;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pend_q, pend_d;
  logic          push_q;
  logic          ferr_q, ferr_d;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_q, perr_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovr_q;
  logic          full, pop, do_push;

  assign rx_s = sync2_q;
  assign tick = (div_q == DW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pend_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick && state_q != S_IDLE) os_d = os_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        // Restart the divider on the start edge so ticks are phase-aligned to it.
        if (!rx_s) begin
          state_d = S_START;
          os_d    = '0;
          div_d   = '0;
        end
      end
      S_START: begin
        if (tick && os_q == 4'd7) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            os_d    = '0;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tick && os_q == 4'd15) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick && os_q == 4'd15) begin
          par_bad_d = (rx_s != ^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick && os_q == 4'd15) begin
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_d = 1'b1;
            else           pend_d = 1'b1;
`else
            pend_d  = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      pend_q  <= 1'b0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
      push_q  <= pend_q;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // A push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = (level_q != '0) && ready;
  assign do_push = push_q && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !pop)      level_d = level_q + LW'(1);
    else if (!do_push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (pop)     rd_q <= rd_q + PW'(1);
      level_q <= level_d;
      ovr_q   <= push_q && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= shift_q;
  end

  assign valid      = (level_q != '0);
  assign data_out   = valid ? mem_q[rd_q] : 8'h00;
  assign fifo_level = level_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
